// File: rtl/wb2axis.sv
// Wishbone-to-AXI4-Stream byte bridge: CPU pushes {last, byte} through a small
// register window into a FIFO that drains onto an AXI4-Stream master port.
module wb2axis #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wb_sel,
   input  logic       i_wb_stb,
   input  logic       i_wb_we,
   input  logic [8:0] i_wb_dat,
   output logic [9:0] o_wb_rdt,
   output logic       o_wb_ack,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ack_q, ack_d;
   logic [9:0]    rdt_q, rdt_d;
   logic [8:0]    mem_q [DEPTH];
   logic [8:0]    mem_d [DEPTH];

   logic full, empty, req, push, pop, flush;

   // full is taken from the registered level, so a pop in the same cycle does
   // not release a stalled write until the following edge
   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign req   = i_wb_stb & ~ack_q;
   assign push  = req & i_wb_we & ~i_wb_sel & ~full;
   assign flush = req & i_wb_we & i_wb_sel & i_wb_dat[0];
   assign pop   = ~empty & i_tready;

   always_comb begin
      ack_d    = req & (~i_wb_we | i_wb_sel | ~full);
      rdt_d    = rdt_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (req & ~i_wb_we)
         rdt_d = {full, empty, 8'(level_q)};

      if (push)
         mem_d[wr_ptr_q] = i_wb_dat;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         if (push & ~pop)
            level_d = level_q + LW'(1);
         else if (~push & pop)
            level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ack_q    <= 1'b0;
         rdt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ack_q    <= ack_d;
         rdt_q    <= rdt_d;
      end
   end

   // Storage is deliberately left uncleared by reset; level/pointers gate it.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign o_wb_ack           = ack_q;
   assign o_wb_rdt           = rdt_q;
   assign o_tvalid           = ~empty;
   assign {o_tlast, o_tdata} = empty ? 9'h000 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_wb2axis.sv
// Directed bench for wb2axis at DEPTH=4: reset, packet, backpressure, status,
// flush and wrap-around scenarios with hand-computed expectations.
module tb_wb2axis;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_wb_sel;
   logic       i_wb_stb;
   logic       i_wb_we;
   logic [8:0] i_wb_dat;
   logic [9:0] o_wb_rdt;
   logic       o_wb_ack;
   logic [7:0] o_tdata;
   logic       o_tlast;
   logic       o_tvalid;
   logic       i_tready;

   int vectors     = 0;
   int miscompares = 0;

   logic [8:0] cap [$];
   logic [8:0] exp_q [$];

   wb2axis #(.DEPTH(4)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wb_sel(i_wb_sel),
      .i_wb_stb(i_wb_stb),
      .i_wb_we (i_wb_we),
      .i_wb_dat(i_wb_dat),
      .o_wb_rdt(o_wb_rdt),
      .o_wb_ack(o_wb_ack),
      .o_tdata (o_tdata),
      .o_tlast (o_tlast),
      .o_tvalid(o_tvalid),
      .i_tready(i_tready)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (i_rst && o_tvalid && i_tready)
         cap.push_back({o_tlast, o_tdata});
   end

   task automatic wb_write(input logic sel, input logic [8:0] dat, output int lat);
      i_wb_sel = sel;
      i_wb_we  = 1'b1;
      i_wb_dat = dat;
      i_wb_stb = 1'b1;
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge i_clk); #1;
         if (o_wb_ack) begin
            lat = c;
            break;
         end
      end
      i_wb_stb = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic wb_read(input logic sel, output logic [9:0] rdt, output int lat);
      i_wb_sel = sel;
      i_wb_we  = 1'b0;
      i_wb_stb = 1'b1;
      lat = -1;
      rdt = '0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge i_clk); #1;
         if (o_wb_ack) begin
            lat = c;
            rdt = o_wb_rdt;
            break;
         end
      end
      i_wb_stb = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      logic [9:0] rdt;
      int lat;
      i_rst = 1'b0; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_sel = 1'b1;
      i_wb_dat = '0; i_tready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge i_clk); #1;
         vectors++;
         if (o_wb_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ack cycle %0d: got %b want 0", k, o_wb_ack);
         end
         vectors++;
         if (o_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tvalid cycle %0d: got %b want 0", k, o_tvalid);
         end
      end
      vectors++;
      if (o_wb_rdt !== 10'h000) begin
         miscompares++;
         $display("FAIL reset_rdt: got %h want 000", o_wb_rdt);
      end
      i_wb_stb = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      wb_read(1'b1, rdt, lat);
      vectors++;
      if (rdt !== 10'h100 || lat !== 1) begin
         miscompares++;
         $display("FAIL reset_status: got %h lat %0d want 100 lat 1", rdt, lat);
      end
   endtask

   task automatic test_single_packet();
      int lat;
      logic [8:0] pkt [3];
      pkt[0] = 9'h041; pkt[1] = 9'h042; pkt[2] = 9'h143;
      cap.delete();
      i_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_wb_sel = 1'b0; i_wb_we = 1'b1; i_wb_dat = pkt[i]; i_wb_stb = 1'b1;
         @(posedge i_clk); #1;
         vectors++;
         if (o_wb_ack !== 1'b1 || o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== pkt[i]) begin
            miscompares++;
            $display("FAIL pkt_ack_latency %0d: ack %b tvalid %b data %h want 1 1 %h",
                     i, o_wb_ack, o_tvalid, {o_tlast, o_tdata}, pkt[i]);
         end
         i_wb_stb = 1'b0;
         @(posedge i_clk); #1;
         lat = 0;
      end
      repeat (3) @(posedge i_clk);
      #1;
      vectors++;
      if (cap.size() !== 3) begin
         miscompares++;
         $display("FAIL pkt_count: got %0d want 3", cap.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cap[i] !== pkt[i]) begin
               miscompares++;
               $display("FAIL pkt_byte %0d: got %h want %h", i, cap[i], pkt[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      cap.delete();
      i_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_write(1'b0, 9'(9'h010 + i), lat);
         vectors++;
         if (lat !== 1) begin
            miscompares++;
            $display("FAIL bp_write %0d: latency %0d want 1", i, lat);
         end
      end
      i_wb_sel = 1'b0; i_wb_we = 1'b1; i_wb_dat = 9'h014; i_wb_stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk); #1;
         vectors++;
         if (o_wb_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stall %0d: ack %b want 0", k, o_wb_ack);
         end
      end
      i_tready = 1'b1;
      @(posedge i_clk); #1;
      i_tready = 1'b0;
      vectors++;
      if (o_wb_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_pop_edge_ack: got %b want 0", o_wb_ack);
      end
      @(posedge i_clk); #1;
      vectors++;
      if (o_wb_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release_ack: got %b want 1", o_wb_ack);
      end
      i_wb_stb = 1'b0;
      @(posedge i_clk); #1;
      vectors++;
      if (cap.size() !== 1 || cap[0] !== 9'h010) begin
         miscompares++;
         $display("FAIL bp_single_pop: size %0d first %h want 1 010", cap.size(),
                  cap.size() > 0 ? cap[0] : 9'h000);
      end
      i_tready = 1'b1;
      repeat (8) @(posedge i_clk);
      #1;
      i_tready = 1'b0;
      vectors++;
      if (cap.size() !== 5) begin
         miscompares++;
         $display("FAIL bp_count: got %0d want 5", cap.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (cap[i] !== 9'(9'h010 + i)) begin
               miscompares++;
               $display("FAIL bp_order %0d: got %h want %h", i, cap[i], 9'(9'h010 + i));
            end
         end
      end
   endtask

   task automatic test_status();
      logic [9:0] rdt;
      int lat;
      i_tready = 1'b0;
      for (int i = 0; i < 3; i++)
         wb_write(1'b0, 9'(9'h021 + i), lat);
      wb_read(1'b0, rdt, lat);
      vectors++;
      if (rdt !== 10'h003 || lat !== 1) begin
         miscompares++;
         $display("FAIL status_three: got %h lat %0d want 003 lat 1", rdt, lat);
      end
      wb_write(1'b0, 9'h024, lat);
      vectors++;
      if (o_wb_rdt !== 10'h003) begin
         miscompares++;
         $display("FAIL status_hold: got %h want 003", o_wb_rdt);
      end
      wb_read(1'b1, rdt, lat);
      vectors++;
      if (rdt !== 10'h204) begin
         miscompares++;
         $display("FAIL status_full: got %h want 204", rdt);
      end
   endtask

   task automatic test_flush();
      logic [9:0] rdt;
      int lat;
      i_tready = 1'b0;
      wb_write(1'b1, 9'h000, lat);
      wb_read(1'b0, rdt, lat);
      vectors++;
      if (rdt !== 10'h204) begin
         miscompares++;
         $display("FAIL flush_noop: got %h want 204", rdt);
      end
      wb_write(1'b1, 9'h001, lat);
      vectors++;
      if (lat !== 1 || o_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_full: lat %0d tvalid %b want 1 0", lat, o_tvalid);
      end
      for (int i = 0; i < 3; i++)
         wb_write(1'b0, 9'(9'h031 + i), lat);
      vectors++;
      if (o_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_refill_tvalid: got %b want 1", o_tvalid);
      end
      i_wb_sel = 1'b1; i_wb_we = 1'b1; i_wb_dat = 9'h001; i_wb_stb = 1'b1;
      @(posedge i_clk); #1;
      i_wb_stb = 1'b0;
      vectors++;
      if (o_wb_ack !== 1'b1 || o_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_three: ack %b tvalid %b want 1 0", o_wb_ack, o_tvalid);
      end
      @(posedge i_clk); #1;
      wb_read(1'b0, rdt, lat);
      vectors++;
      if (rdt !== 10'h100) begin
         miscompares++;
         $display("FAIL flush_status: got %h want 100", rdt);
      end
      cap.delete();
      wb_write(1'b0, 9'h041, lat);
      wb_write(1'b0, 9'h042, lat);
      i_wb_sel = 1'b1; i_wb_we = 1'b1; i_wb_dat = 9'h001; i_wb_stb = 1'b1;
      i_tready = 1'b1;
      @(posedge i_clk); #1;
      i_tready = 1'b0;
      i_wb_stb = 1'b0;
      vectors++;
      if (o_wb_ack !== 1'b1 || o_tvalid !== 1'b0 || cap.size() !== 1) begin
         miscompares++;
         $display("FAIL flush_with_pop: ack %b tvalid %b pops %0d want 1 0 1",
                  o_wb_ack, o_tvalid, cap.size());
      end
      @(posedge i_clk); #1;
      wb_read(1'b1, rdt, lat);
      vectors++;
      if (rdt !== 10'h100) begin
         miscompares++;
         $display("FAIL flush_pop_status: got %h want 100", rdt);
      end
      cap.delete();
   endtask

   task automatic test_wrap();
      int lat;
      int timeouts;
      bit done;
      cap.delete();
      exp_q.delete();
      timeouts = 0;
      done = 1'b0;
      for (int i = 0; i < 13; i++)
         exp_q.push_back({(i % 4) == 3, 8'(8'h80 + i)});
      fork
         begin
            for (int i = 0; i < 13; i++) begin
               wb_write(1'b0, exp_q[i], lat);
               if (lat < 0)
                  timeouts++;
            end
            done = 1'b1;
         end
         begin
            for (int c = 0; c < 3000 && !done; c++) begin
               @(posedge i_clk); #1;
               i_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      vectors++;
      if (timeouts !== 0) begin
         miscompares++;
         $display("FAIL wrap_write_timeout: got %0d timeouts want 0", timeouts);
      end
      i_tready = 1'b1;
      repeat (10) @(posedge i_clk);
      #1;
      i_tready = 1'b0;
      vectors++;
      if (cap.size() !== 13) begin
         miscompares++;
         $display("FAIL wrap_count: got %0d want 13", cap.size());
      end else begin
         for (int i = 0; i < 13; i++) begin
            vectors++;
            if (cap[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL wrap_byte %0d: got %h want %h", i, cap[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_backpressure();
      test_status();
      test_flush();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
      $fatal(1, "watchdog");
   end

endmodule
